bit_serial_subtractor: RTL and testbench
========================================

Name: bit_serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing A − B − borrow_in, LSB first, one bit per clock.
- Uses a single full-subtractor cell and a borrow flip-flop.
- Companion to the combinational full-adder cell: the inverse arithmetic operation, in area-minimal serial form for TinyTapeout tiles.
- Operands enter on a valid/ready handshake; the result leaves on a second valid/ready handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..16.

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start_valid  input  1  operands presented
- start_ready  output  1  block can accept operands (high only in IDLE)
- a_in  input  WIDTH  minuend
- b_in  input  WIDTH  subtrahend
- borrow_in  input  1  initial borrow
- done_valid  output  1  result available (high only in DONE)
- done_ready  input  1  consumer accepts result
- diff_out  output  WIDTH  difference, valid while done_valid
- borrow_out  output  1  final borrow (1 = unsigned A < B + borrow_in)
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async assert, sync deassert by caller):
  - state=IDLE; all shift registers, borrow FF and bit counter cleared.
  - Outputs: start_ready=1, done_valid=0, diff_out=0, borrow_out=0, busy=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On edge with start_valid=1: capture a_in, b_in into shift registers and borrow_in into borrow FF; cnt=0; go to RUN.
- RUN:
  - Each edge applies the cell to the LSBs of both shift registers and the borrow FF: d = a^b^bw; bw_next = (~a&b) | (~(a^b)&bw).
  - d shifts into the MSB of the result register, which shifts right. Operand registers shift right. Borrow FF takes bw_next. cnt increments.
  - When cnt==WIDTH-1 on an edge: go to DONE.
  - start_valid is ignored; start_ready=0.
- Latency: acceptance at edge E0; done_valid goes high after edge E_WIDTH, i.e. WIDTH cycles later.
- DONE:
  - done_valid=1; diff_out = result register; borrow_out = borrow FF.
  - Both are held stable until the handshake.
  - On edge with done_ready=1: go to IDLE. start_ready rises the next cycle; no same-cycle re-accept.
- Backpressure: DONE may last indefinitely; outputs must not change.
- Arithmetic: modulo 2^WIDTH; diff_out = (A − B − borrow_in) mod 2^WIDTH.
- diff_out=0 and borrow_out=0 whenever state≠DONE; results are masked, not left stale.
- Reset mid-RUN or mid-DONE: immediate return to reset state; the partial result is discarded and never presented.
- Counter width: $clog2(WIDTH); it must not wrap before the transition.

Optional Feature:
- Macro SERIAL_SUB_SIGNED_OVF_EN.
- Defined:
  - Adds output port ovf_out (1 bit).
  - Equals the two's-complement overflow of the final bit step, i.e. the borrow into the MSB XOR the borrow out of the MSB.
  - Captured on the last RUN edge; valid in DONE; 0 otherwise and at reset.
- Undefined: port absent; no extra flops.

Decomposition:
- Package bit_serial_sub_pkg:
  - state typedef enum logic [1:0] {IDLE, RUN, DONE}.
  - Localparam defaults: WIDTH_DEFAULT = 8.
- Sub-module full_subtractor_cell:
  - Purely combinational.
  - Ports A, B, Bin, D, Bout, mirroring the full-adder cell's port style.
  - Instantiated once.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, borrow_in=0, done_ready=1 → done_valid exactly 8 cycles after acceptance; diff_out=0x02, borrow_out=0.
- a=0x03, b=0x05, borrow_in=0 → diff_out=0xFE, borrow_out=1; with SERIAL_SUB_SIGNED_OVF_EN, ovf_out=0.
- a=0x00, b=0x00, borrow_in=1 → diff_out=0xFF, borrow_out=1.
- a=0x80, b=0x01 with SERIAL_SUB_SIGNED_OVF_EN → diff_out=0x7F, borrow_out=0, ovf_out=1.
- Hold done_ready=0 for 20 cycles after done_valid → diff_out/borrow_out stable; start_valid pulses ignored (start_ready=0); release → IDLE, start_ready=1 next cycle.
- Drop rst_n at RUN cycle 4 → all outputs reset immediately; new start afterward with a=0xAA, b=0x55 → diff_out=0x55, borrow_out=0, no residue from the aborted operation.

Source files
------------

// File: rtl/bit_serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package bit_serial_sub_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor_cell.sv
// Combinational full-subtractor cell: D = A - B - Bin, Bout = borrow out.
module full_subtractor_cell (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    always_comb begin
        D    = A ^ B ^ Bin;
        Bout = (~A & B) | (~(A ^ B) & Bin);
    end

endmodule

// File: rtl/bit_serial_subtractor.sv
// Bit-serial A - B - borrow_in, LSB first, one bit per clock, valid/ready on both sides.
// Optional signed-overflow output enabled by `define SERIAL_SUB_SIGNED_OVF_EN.
module bit_serial_subtractor
    import bit_serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             borrow_in,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out,
    output logic             busy
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    output logic             ovf_out
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic             bw_q;
    logic [CW-1:0]    cnt_q;
    logic             cell_d, cell_bout;

    full_subtractor_cell u_cell (
        .A    (a_q[0]),
        .B    (b_q[0]),
        .Bin  (bw_q),
        .D    (cell_d),
        .Bout (cell_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Results are masked outside DONE so nothing stale is ever presented.
    always_comb begin
        state_d     = state_q;
        start_ready = 1'b0;
        done_valid  = 1'b0;
        busy        = 1'b0;
        diff_out    = '0;
        borrow_out  = 1'b0;
        case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_q == LAST_CNT) state_d = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done_valid = 1'b1;
                diff_out   = res_q;
                borrow_out = bw_q;
                if (done_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            bw_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        a_q   <= a_in;
                        b_q   <= b_in;
                        res_q <= '0;
                        bw_q  <= borrow_in;
                        cnt_q <= '0;
                    end
                end
                RUN: begin
                    a_q   <= {1'b0, a_q[WIDTH-1:1]};
                    b_q   <= {1'b0, b_q[WIDTH-1:1]};
                    res_q <= {cell_d, res_q[WIDTH-1:1]};
                    bw_q  <= cell_bout;
                    cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic ovf_q;

    // On the last step bw_q is the borrow into the MSB and cell_bout the borrow out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == IDLE && start_valid) begin
            ovf_q <= 1'b0;
        end else if (state_q == RUN && cnt_q == LAST_CNT) begin
            ovf_q <= bw_q ^ cell_bout;
        end
    end

    always_comb begin
        ovf_out = (state_q == DONE) ? ovf_q : 1'b0;
    end
`endif

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed self-checking bench for bit_serial_subtractor (WIDTH = 8).
module tb_bit_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start_valid;
    logic       start_ready;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       borrow_in;
    logic       done_valid;
    logic       done_ready;
    logic [7:0] diff_out;
    logic       borrow_out;
    logic       busy;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic       ovf_out;
`endif

    int checks = 0;
    int errors = 0;

    bit_serial_subtractor #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .borrow_in   (borrow_in),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .diff_out    (diff_out),
        .borrow_out  (borrow_out),
        .busy        (busy)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        ,
        .ovf_out     (ovf_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept operands, wait for done_valid, return cycle count; done_ready left low.
    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          output int cycles);
        int guard;
        guard = 0;
        while (!start_ready && guard < 40) begin
            tick();
            guard++;
        end
        chk("start_ready_before_accept", 16'(start_ready), 16'd1);
        a_in        = a;
        b_in        = b;
        borrow_in   = bin;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        a_in        = 8'h00;
        b_in        = 8'h00;
        borrow_in   = 1'b0;
        chk("busy_in_run", 16'(busy), 16'd1);
        cycles = 0;
        while (!done_valid && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    task automatic finish_op(input string tag, input logic [7:0] exp_d, input logic exp_bw);
        chk({tag, "_diff"}, 16'(diff_out), 16'(exp_d));
        chk({tag, "_borrow"}, 16'(borrow_out), 16'(exp_bw));
        chk({tag, "_start_ready_in_done"}, 16'(start_ready), 16'd0);
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        chk({tag, "_done_valid_after"}, 16'(done_valid), 16'd0);
        chk({tag, "_start_ready_after"}, 16'(start_ready), 16'd1);
        chk({tag, "_diff_masked"}, 16'(diff_out), 16'd0);
    endtask

    initial begin
        int cyc;
        rst_n       = 1'b0;
        start_valid = 1'b0;
        a_in        = 8'h00;
        b_in        = 8'h00;
        borrow_in   = 1'b0;
        done_ready  = 1'b0;
        #12;
        chk("rst_start_ready", 16'(start_ready), 16'd1);
        chk("rst_done_valid", 16'(done_valid), 16'd0);
        chk("rst_diff", 16'(diff_out), 16'd0);
        chk("rst_borrow", 16'(borrow_out), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        rst_n = 1'b1;
        tick();

        launch(8'h05, 8'h03, 1'b0, cyc);
        chk("latency_5_3", 16'(cyc), 16'd8);
        finish_op("5m3", 8'h02, 1'b0);

        launch(8'h03, 8'h05, 1'b0, cyc);
        chk("latency_3_5", 16'(cyc), 16'd8);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        chk("3m5_ovf", 16'(ovf_out), 16'd0);
`endif
        finish_op("3m5", 8'hFE, 1'b1);

        launch(8'h00, 8'h00, 1'b1, cyc);
        finish_op("0m0m1", 8'hFF, 1'b1);

        launch(8'h80, 8'h01, 1'b0, cyc);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        chk("80m01_ovf", 16'(ovf_out), 16'd1);
`endif
        finish_op("80m01", 8'h7F, 1'b0);

        launch(8'hFF, 8'hFF, 1'b1, cyc);
        finish_op("FFmFFm1", 8'hFF, 1'b1);

        launch(8'h10, 8'h0F, 1'b1, cyc);
        finish_op("10m0Fm1", 8'h00, 1'b0);

        // Backpressure: hold DONE for 20 cycles while poking start_valid.
        launch(8'h3C, 8'h1A, 1'b0, cyc);
        chk("bp_done_valid", 16'(done_valid), 16'd1);
        for (int i = 0; i < 20; i++) begin
            start_valid = i[0];
            a_in        = 8'hEE;
            b_in        = 8'h11;
            chk("bp_start_ready", 16'(start_ready), 16'd0);
            chk("bp_diff_stable", 16'(diff_out), 16'h22);
            chk("bp_borrow_stable", 16'(borrow_out), 16'd0);
            tick();
        end
        start_valid = 1'b0;
        chk("bp_still_done", 16'(done_valid), 16'd1);
        finish_op("bp", 8'h22, 1'b0);

        // Reset during RUN cycle 4, then a fresh operation.
        a_in        = 8'hFF;
        b_in        = 8'h01;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_run_busy", 16'(busy), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_start_ready", 16'(start_ready), 16'd1);
        chk("abort_done_valid", 16'(done_valid), 16'd0);
        chk("abort_diff", 16'(diff_out), 16'd0);
        chk("abort_borrow", 16'(borrow_out), 16'd0);
        chk("abort_busy", 16'(busy), 16'd0);
        #6;
        rst_n = 1'b1;
        tick();
        launch(8'hAA, 8'h55, 1'b0, cyc);
        chk("latency_AA_55", 16'(cyc), 16'd8);
        finish_op("AAm55", 8'h55, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
